layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Controller that sequences a one-hot-addressed layer weight ROM to compute one fully-connected layer pass. It accepts a binary activation vector from the previous layer and walks the set bits, lowest first. For each set bit it drives the ROM's one-hot address and adds the returned per-output-neuron weight slices into `neurons_out` signed accumulators. It then presents the accumulated vector to the next layer over a valid/ready handshake. It sits between the activation register of layer N and the ROM-layer instance holding the N→N+1 weights.

## Interface
- `w_size`, 8, weight width in bits; two's-complement signed
- `neurons_in`, 4, previous-layer neuron count; ROM address width
- `neurons_out`, 4, next-layer neuron count
- `acc_size`, 16, accumulator width per output neuron; must be ≥ `w_size`
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  activation vector valid
- `in_ready`  out  1  sequencer can accept a vector
- `in_act`  in  `neurons_in`  activation bitmask; bit i = previous-layer neuron i active
- `rom_addr`  out  `neurons_in`  one-hot ROM address; all-zero when not scanning
- `rom_data`  in  `neurons_out*w_size`  ROM word, combinational response to `rom_addr`; slice j = bits `[j*w_size +: w_size]`
- `out_valid`  out  1  accumulated result valid
- `out_ready`  in  1  downstream accepts result
- `out_acc`  out  `neurons_out*acc_size`  accumulators; slice j = bits `[j*acc_size +: acc_size]`
- `busy`  out  1  high in SCAN and DONE

## Operation
- States: IDLE, SCAN, DONE; encoding `layer_seq_state_t`.
- IDLE: `in_ready`=1. On `in_valid & in_ready`:
  - latch `in_act` into the `pending` mask.
  - clear all accumulators.
  - go to SCAN if `in_act`≠0, else DONE.
- SCAN, each cycle:
  - `rom_addr` = lowest set bit of `pending`.
  - each accumulator j += sign-extended `rom_data` slice j.
  - clear that bit in `pending`.
  - when the cleared bit was the last set bit, go to DONE.
- DONE:
  - `out_valid`=1; `out_acc` stable.
  - on `out_ready`, go to IDLE; `out_valid` drops next cycle.
- `in_ready`=0 outside IDLE. `in_act` changes outside IDLE are ignored.
- Arithmetic: signed addition in `acc_size` bits. Overflow behaviour is set by the macro under Configuration.
- Reset values (`rst_n`=0 at an edge): state IDLE, `pending`=0, accumulators=0, `rom_addr`=0, `out_valid`=0, `busy`=0. `in_ready` is 1 from the first cycle after reset.
- Reset mid-SCAN or mid-DONE aborts the pass. No partial result is emitted.
- `out_ready` asserted while not in DONE is ignored.

## Timing
- Accept at edge T. A vector with k set bits occupies SCAN cycles T+1..T+k.
- `out_valid` is high from cycle T+k+1.
- k=0: `out_valid` at T+1; `out_acc`=0.
- Throughput: one ROM read per cycle, with no bubbles between set bits.
- DONE→IDLE handshake at edge D puts `in_ready`=1 in cycle D+1.
- The next vector cannot be accepted in the same cycle as the output handshake.
- Minimum pass is 2 cycles (accept + DONE) plus k.
- `rom_data` is sampled in the same cycle `rom_addr` is driven. The ROM must be combinational.

## Configuration
- `LAYER_SEQ_SAT_EN` defined: each accumulator add saturates to +2^(acc_size-1)-1 or -2^(acc_size-1).
- Not defined: two's-complement wrap-around modulo 2^acc_size.
- Macro affects only the add; interface and timing are identical in both builds.

## Structure
- Package `layer_seq_pkg`:
  - `layer_seq_state_t` enum.
  - function `sat_add` (signed, parameterised width via automatic function with explicit widths).
- Sub-module `lsb_onehot`: combinational isolation of the lowest set bit, `x & -x`, width `neurons_in`. Drives `rom_addr` and the `pending` clear.
- Accumulators are a packed array of `neurons_out` signed `acc_size` registers.

## Test plan
Defaults for all scenarios: w_size=8, neurons_in=4, neurons_out=4, acc_size=16. ROM row i holds weights {i+1, -(i+1), 10, 0x7F} for outputs 0..3.
- `in_act`=4'b1011 -> `rom_addr` sequence 0001, 0010, 1000 over 3 SCAN cycles. `out_valid` at T+4 with `out_acc`={7, -7, 30, 381}.
- `in_act`=0 -> `out_valid` at T+1, all `out_acc` slices 0, `rom_addr` never nonzero.
- `out_ready` held low for 5 cycles in DONE -> `out_valid` and `out_acc` stable and `in_ready`=0 throughout. After `out_ready`=1, `in_ready`=1 one cycle later.
- acc_size=8 with `in_act`=4'b1111 -> slice 3 sums 4×0x7F. Build with `LAYER_SEQ_SAT_EN` gives 127; build without gives -4 (0xFC).
- `rst_n`=0 for one cycle during the 2nd SCAN cycle -> next cycle `rom_addr`=0, `busy`=0, `in_ready`=1, `out_valid` never asserted for that pass.
- Back-to-back vectors 4'b0001 then 4'b1000 with `in_valid` held and `out_ready`=1 -> two results {1,-1,10,127} then {4,-4,10,127}. The second is accepted exactly one cycle after the first output handshake.

Source files
------------

// File: rtl/layer_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : layer_seq_pkg                                          |
// | Description : Shared state encoding and saturating add helper for    |
// |               the layer sequencer.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package layer_seq_pkg;

  localparam int C_SAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } layer_seq_state_t;

  // Operands arrive sign-extended to C_SAT_W; the result is clamped to a
  // signed range of 'width' bits, so callers truncate back to their width.
  function automatic logic signed [C_SAT_W-1:0] sat_add(
    input logic signed [C_SAT_W-1:0] a,
    input logic signed [C_SAT_W-1:0] b,
    input int                        width
  );
    logic signed [C_SAT_W:0] w_sum;
    logic signed [C_SAT_W:0] w_max;
    logic signed [C_SAT_W:0] w_min;
    w_sum = {a[C_SAT_W-1], a} + {b[C_SAT_W-1], b};
    w_max = ((C_SAT_W+1)'(1) << (width - 1)) - (C_SAT_W+1)'(1);
    w_min = ~w_max;
    if (w_sum > w_max)
      return w_max[C_SAT_W-1:0];
    else if (w_sum < w_min)
      return w_min[C_SAT_W-1:0];
    else
      return w_sum[C_SAT_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsb_onehot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lsb_onehot                                             |
// | Description : Isolates the lowest set bit of a vector (x & -x).      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module lsb_onehot #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [WIDTH-1:0] o_lsb
);

  assign o_lsb = i_vec & (-i_vec);

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : layer_sequencer                                        |
// | Description : Walks set activation bits, accumulates one-hot ROM     |
// |               weight rows, hands the result on via valid/ready.      |
// |               LAYER_SEQ_SAT_EN selects saturating accumulation.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int W_SIZE      = 8,
  parameter int NEURONS_IN  = 4,
  parameter int NEURONS_OUT = 4,
  parameter int ACC_SIZE    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NEURONS_IN-1:0]           in_act,
  output logic [NEURONS_IN-1:0]           rom_addr,
  input  logic [NEURONS_OUT*W_SIZE-1:0]   rom_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NEURONS_OUT*ACC_SIZE-1:0] out_acc,
  output logic                            busy
);

  typedef logic signed [ACC_SIZE-1:0] acc_t;

  layer_seq_state_t         r_state;
  layer_seq_state_t         w_state_nxt;
  logic [NEURONS_IN-1:0]    r_pending;
  logic [NEURONS_IN-1:0]    w_lsb;
  logic [NEURONS_IN-1:0]    w_pending_nxt;
  acc_t [NEURONS_OUT-1:0]   r_acc;
  acc_t [NEURONS_OUT-1:0]   w_acc_sum;

  lsb_onehot #(
    .WIDTH (NEURONS_IN)
  ) u_lsb (
    .i_vec (r_pending),
    .o_lsb (w_lsb)
  );

  assign w_pending_nxt = r_pending & ~w_lsb;

  for (genvar j = 0; j < NEURONS_OUT; j++) begin : g_add
    acc_t w_ext;
    assign w_ext = acc_t'(signed'(rom_data[j*W_SIZE +: W_SIZE]));
`ifdef LAYER_SEQ_SAT_EN
    assign w_acc_sum[j] = acc_t'(sat_add(C_SAT_W'(signed'(r_acc[j])),
                                         C_SAT_W'(w_ext), ACC_SIZE));
`else
    assign w_acc_sum[j] = signed'(r_acc[j]) + w_ext;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    rom_addr    = '0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          w_state_nxt = (in_act != '0) ? ST_SCAN : ST_DONE;
      end
      ST_SCAN: begin
        busy     = 1'b1;
        rom_addr = w_lsb;
        if (w_pending_nxt == '0)
          w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Accumulators hold their value through DONE so out_acc stays stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_acc     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_pending <= in_act;
            r_acc     <= '0;
          end
        end
        ST_SCAN: begin
          r_pending <= w_pending_nxt;
          r_acc     <= w_acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign out_acc = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_layer_sequencer                                     |
// | Description : Self-checking bench for layer_sequencer.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_act;
  logic [3:0]  rom_addr;
  logic [31:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_acc;
  logic        busy;

  logic        n_in_valid;
  logic        n_in_ready;
  logic [3:0]  n_in_act;
  logic [3:0]  n_rom_addr;
  logic [31:0] n_rom_data;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [31:0] n_out_acc;
  logic        n_busy;

  int total = 0;
  int bad   = 0;
  int exp_acc[4];

  always #5 clk = ~clk;

  // Row i holds {i+1, -(i+1), 10, 0x7F}; a zero address returns zero.
  function automatic logic [31:0] rom_word(input logic [3:0] addr);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++)
      if (addr == 4'(1 << i))
        w = {8'h7F, 8'd10, 8'(-(i + 1)), 8'(i + 1)};
    return w;
  endfunction

  assign rom_data   = rom_word(rom_addr);
  assign n_rom_data = rom_word(n_rom_addr);

  layer_sequencer #(
    .W_SIZE(8), .NEURONS_IN(4), .NEURONS_OUT(4), .ACC_SIZE(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .busy(busy)
  );

  layer_sequencer #(
    .W_SIZE(8), .NEURONS_IN(4), .NEURONS_OUT(4), .ACC_SIZE(8)
  ) dut_narrow (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_act(n_in_act), .rom_addr(n_rom_addr), .rom_data(n_rom_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_acc(n_out_acc),
    .busy(n_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum the weight rows of every active input neuron.
  task automatic calc_exp(input logic [3:0] act);
    for (int j = 0; j < 4; j++) exp_acc[j] = 0;
    for (int i = 0; i < 4; i++) begin
      if (act[i]) begin
        exp_acc[0] += i + 1;
        exp_acc[1] -= i + 1;
        exp_acc[2] += 10;
        exp_acc[3] += 127;
      end
    end
  endtask

  task automatic run_pass(input logic [3:0] act, input int hold, input string name);
    logic [3:0] q_addr[$];
    logic [15:0] got;
    calc_exp(act);
    for (int i = 0; i < 4; i++)
      if (act[i]) q_addr.push_back(4'(1 << i));
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s accept_ready got=%b want=1", name, in_ready);
    end
    in_valid = 1'b1; in_act = act;
    tick();
    in_valid = 1'b0;
    foreach (q_addr[k]) begin
      total++;
      if (rom_addr !== q_addr[k] || busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s scan%0d got addr=%b busy=%b ov=%b ir=%b want addr=%b busy=1 ov=0 ir=0",
                 name, k, rom_addr, busy, out_valid, in_ready, q_addr[k]);
      end
      in_act    = 4'($urandom);
      out_ready = (k == q_addr.size() - 1) ? 1'b0 : 1'($urandom);
      tick();
    end
    out_ready = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || rom_addr !== 4'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s done%0d got ov=%b ir=%b addr=%b busy=%b want ov=1 ir=0 addr=0 busy=1",
                 name, h, out_valid, in_ready, rom_addr, busy);
      end
      for (int j = 0; j < 4; j++) begin
        got = out_acc[j*16 +: 16];
        total++;
        if (got !== 16'(exp_acc[j])) begin
          bad++;
          $display("FAIL %s acc%0d got=%0d want=%0d", name, j, $signed(got), exp_acc[j]);
        end
      end
      if (h < hold) tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s release got ov=%b ir=%b busy=%b want ov=0 ir=1 busy=0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_act = '0; out_ready = 1'b0;
    n_in_valid = 1'b0; n_in_act = '0; n_out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 4'b0 || out_acc !== 64'b0) begin
      bad++;
      $display("FAIL reset got ir=%b ov=%b busy=%b addr=%b acc=%h want ir=1 ov=0 busy=0 addr=0 acc=0",
               in_ready, out_valid, busy, rom_addr, out_acc);
    end
    tick();
  endtask

  task automatic test_pattern();
    run_pass(4'b1011, 0, "pattern_1011");
  endtask

  task automatic test_zero();
    run_pass(4'b0000, 0, "zero_act");
  endtask

  task automatic test_stall();
    run_pass(4'b0110, 5, "stall");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      run_pass(4'($urandom), int'($urandom_range(0, 3)), "random");
  endtask

  task automatic test_reset_mid_scan();
    in_valid = 1'b1; in_act = 4'b1111;
    tick();
    in_valid = 1'b0;
    tick();
    total++;
    if (rom_addr !== 4'b0010) begin
      bad++; $display("FAIL midrst_scan2 addr got=%b want=0010", rom_addr);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (rom_addr !== 4'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== 64'b0) begin
      bad++;
      $display("FAIL midrst_after got addr=%b busy=%b ir=%b ov=%b acc=%h want 0,0,1,0,0",
               rom_addr, busy, in_ready, out_valid, out_acc);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL midrst_no_output cycle%0d ov got=%b want=0", c, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    in_valid = 1'b1; in_act = 4'b0001; out_ready = 1'b1;
    tick();
    total++;
    if (rom_addr !== 4'b0001) begin
      bad++; $display("FAIL b2b_scan1 addr got=%b want=0001", rom_addr);
    end
    in_act = 4'b1000;
    tick();
    calc_exp(4'b0001);
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_done1 ov got=%b want=1", out_valid);
    end
    for (int j = 0; j < 4; j++) begin
      got = out_acc[j*16 +: 16];
      total++;
      if (got !== 16'(exp_acc[j])) begin
        bad++; $display("FAIL b2b_acc1_%0d got=%0d want=%0d", j, $signed(got), exp_acc[j]);
      end
    end
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_gap got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (rom_addr !== 4'b1000 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_scan2 got addr=%b busy=%b want addr=1000 busy=1", rom_addr, busy);
    end
    tick();
    calc_exp(4'b1000);
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_done2 ov got=%b want=1", out_valid);
    end
    for (int j = 0; j < 4; j++) begin
      got = out_acc[j*16 +: 16];
      total++;
      if (got !== 16'(exp_acc[j])) begin
        bad++; $display("FAIL b2b_acc2_%0d got=%0d want=%0d", j, $signed(got), exp_acc[j]);
      end
    end
    tick();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_end got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_narrow_acc();
    logic [7:0] want[4];
    logic [7:0] got;
    int full;
    calc_exp(4'b1111);
    for (int j = 0; j < 4; j++) begin
      full = exp_acc[j];
`ifdef LAYER_SEQ_SAT_EN
      if (full > 127) full = 127;
      if (full < -128) full = -128;
`endif
      want[j] = 8'(full);
    end
    n_out_ready = 1'b1;
    n_in_valid  = 1'b1; n_in_act = 4'b1111;
    tick();
    n_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    total++;
    if (n_out_valid !== 1'b1) begin
      bad++; $display("FAIL narrow_done ov got=%b want=1", n_out_valid);
    end
    for (int j = 0; j < 4; j++) begin
      got = n_out_acc[j*8 +: 8];
      total++;
      if (got !== want[j]) begin
        bad++; $display("FAIL narrow_acc%0d got=%h want=%h", j, got, want[j]);
      end
    end
    tick();
    total++;
    if (n_in_ready !== 1'b1 || n_out_valid !== 1'b0) begin
      bad++; $display("FAIL narrow_release got ir=%b ov=%b want ir=1 ov=0", n_in_ready, n_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_zero();
    test_stall();
    test_random();
    test_reset_mid_scan();
    test_back_to_back();
    test_narrow_acc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
